// File: rtl/elbeth_dmem_responder.sv
// Data-memory slave for the pipeline dmem en/ready interface: byte-lane stores, extended loads, fixed-latency ready pulse.
// Optional macro ELBETH_DMEM_MISALIGN_TRAP_EN reports misaligned/illegal requests as faults instead of force-aligning them.
module elbeth_dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_en,
  input  logic        dmem_wr,
  input  logic [3:0]  dmem_size,
  input  logic        dmem_sign,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              count;
  logic [31:0]             mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   index;
  logic                    is_byte;
  logic                    is_half;
  logic                    is_word;
  logic                    fault;
  logic [1:0]              offset;
  logic [3:0]              byte_en;
  logic [31:0]             write_data;
  logic [31:0]             word_rd;
  logic [31:0]             shifted;
  logic [31:0]             load_data;
  logic                    fire;
  logic                    unused_addr;

  assign index       = dmem_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^dmem_addr[31:ADDR_WIDTH+2];

  // Size decode; without the trap build, bad requests are silently aligned.
  always_comb begin
    is_byte = (dmem_size == 4'b0001);
    is_half = (dmem_size == 4'b0010);
`ifdef ELBETH_DMEM_MISALIGN_TRAP_EN
    is_word = (dmem_size == 4'b1000);
    fault   = !(is_byte || is_half || is_word) ||
              (is_half && dmem_addr[0]) ||
              (is_word && (dmem_addr[1:0] != 2'b00));
    offset  = dmem_addr[1:0];
`else
    is_word = !(is_byte || is_half);
    fault   = 1'b0;
    if (is_byte)
      offset = dmem_addr[1:0];
    else if (is_half)
      offset = {dmem_addr[1], 1'b0};
    else
      offset = 2'b00;
`endif
  end

  always_comb begin
    if (is_byte) begin
      byte_en    = 4'b0001 << offset;
      write_data = {4{dmem_wdata[7:0]}};
    end else if (is_half) begin
      byte_en    = offset[1] ? 4'b1100 : 4'b0011;
      write_data = {2{dmem_wdata[15:0]}};
    end else begin
      byte_en    = 4'b1111;
      write_data = dmem_wdata;
    end
  end

  // Selected lane is shifted down to bit 0 before extension.
  always_comb begin
    word_rd = mem[index];
    shifted = word_rd >> {offset, 3'b000};
    if (is_byte)
      load_data = {{24{dmem_sign & shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_data = {{16{dmem_sign & shifted[15]}}, shifted[15:0]};
    else
      load_data = word_rd;
  end

  // The edge that enters RESP is the one that commits the store and registers the response.
  assign fire = dmem_en &&
                (((state == IDLE) && (LATENCY == 1)) ||
                 ((state == WAIT) && (count <= 4'd1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      dmem_ready <= 1'b0;
      dmem_fault <= 1'b0;
      dmem_rdata <= 32'd0;
    end else begin
      dmem_ready <= fire;
      dmem_fault <= fire && fault;
      dmem_rdata <= (fire && !dmem_wr && !fault) ? load_data : 32'd0;
      case (state)
        IDLE: begin
          if (dmem_en) begin
            if (LATENCY == 1) begin
              state <= RESP;
              count <= 4'd0;
            end else begin
              state <= WAIT;
              count <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (!dmem_en) begin
            state <= IDLE;
            count <= 4'd0;
          end else if (count <= 4'd1) begin
            state <= RESP;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Storage has no reset; an aborted or reset transaction never reaches a write.
  always_ff @(posedge clk) begin
    if (rst && fire && dmem_wr && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[index][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// Scoreboard bench for elbeth_dmem_responder; expectations follow ELBETH_DMEM_MISALIGN_TRAP_EN when defined.
module tb_elbeth_dmem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_en = 1'b0;
  logic        dmem_wr = 1'b0;
  logic [3:0]  dmem_size = 4'b1000;
  logic        dmem_sign = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_fault;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        fault;
    string       tag;
  } expect_t;

  expect_t sb[$];
  int      cyc = 0;
  int      tests = 0;
  int      failures = 0;
  bit      mon_on = 1'b0;

  elbeth_dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_en    (dmem_en),
    .dmem_wr    (dmem_wr),
    .dmem_size  (dmem_size),
    .dmem_sign  (dmem_sign),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_fault (dmem_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response is due exactly LAT cycles after issue; every other cycle must be quiet.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() > 0 && cyc == sb[0].due) begin
        expect_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_ready"}, {31'd0, dmem_ready}, 32'd1);
        checkOutput({e.tag, "_rdata"}, dmem_rdata, e.rdata);
        checkOutput({e.tag, "_fault"}, {31'd0, dmem_fault}, {31'd0, e.fault});
      end else begin
        checkOutput("quiet_ready", {31'd0, dmem_ready}, 32'd0);
        checkOutput("quiet_fault", {31'd0, dmem_fault}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic wr, input logic [3:0] size,
                               input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_fault, input bit keep);
    expect_t e;
    int n;
    @(posedge clk);
    #1;
    dmem_en    = 1'b1;
    dmem_wr    = wr;
    dmem_size  = size;
    dmem_sign  = sign;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    e.due   = cyc + LAT;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.tag   = tag;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmem_ready && n < 20);
    if (!dmem_ready)
      checkOutput({tag, "_timeout"}, {31'd0, dmem_ready}, 32'd1);
    if (!keep) begin
      @(posedge clk);
      #1;
      dmem_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'd0, dmem_ready}, 32'd0);
    checkOutput("reset_fault", {31'd0, dmem_fault}, 32'd0);
    checkOutput("reset_rdata", dmem_rdata, 32'd0);
    rst    = 1'b1;
    mon_on = 1'b1;

    applyStimulus("st_word",   1'b1, 4'b1000, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    applyStimulus("ld_word",   1'b0, 4'b1000, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus("st_byte",   1'b1, 4'b0001, 1'b0, 32'h13, 32'hABCDEF80, 32'h0, 1'b0, 1'b0);
    applyStimulus("ld_word2",  1'b0, 4'b1000, 1'b1, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);
    applyStimulus("ld_byte_s", 1'b0, 4'b0001, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    applyStimulus("ld_byte_u", 1'b0, 4'b0001, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b0);
    applyStimulus("ld_half_s", 1'b0, 4'b0010, 1'b1, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 1'b0);
    applyStimulus("ld_half_u", 1'b0, 4'b0010, 1'b0, 32'h12, 32'h0, 32'h000080AD, 1'b0, 1'b0);
    applyStimulus("st_half",   1'b1, 4'b0010, 1'b0, 32'h10, 32'h55551234, 32'h0, 1'b0, 1'b0);
    applyStimulus("ld_word3",  1'b0, 4'b1000, 1'b0, 32'h10, 32'h0, 32'h80AD1234, 1'b0, 1'b0);
    applyStimulus("ld_byte1",  1'b0, 4'b0001, 1'b1, 32'h11, 32'h0, 32'h00000012, 1'b0, 1'b0);
    applyStimulus("ld_byte0",  1'b0, 4'b0001, 1'b1, 32'h10, 32'h0, 32'h00000034, 1'b0, 1'b0);

`ifdef ELBETH_DMEM_MISALIGN_TRAP_EN
    applyStimulus("mis_ld_word", 1'b0, 4'b1000, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus("mis_st_word", 1'b1, 4'b1000, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    applyStimulus("mis_ld_half", 1'b0, 4'b0010, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus("bad_size",    1'b0, 4'b0100, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus("after_fault", 1'b0, 4'b1000, 1'b0, 32'h10, 32'h0, 32'h80AD1234, 1'b0, 1'b0);
`else
    applyStimulus("mis_ld_word", 1'b0, 4'b1000, 1'b0, 32'h11, 32'h0, 32'h80AD1234, 1'b0, 1'b0);
    applyStimulus("mis_st_half", 1'b1, 4'b0010, 1'b0, 32'h13, 32'h0000BEEF, 32'h0, 1'b0, 1'b0);
    applyStimulus("bad_size",    1'b0, 4'b0100, 1'b0, 32'h10, 32'h0, 32'hBEEF1234, 1'b0, 1'b0);
`endif

    applyStimulus("st_base", 1'b1, 4'b1000, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);

    // Store abandoned by dropping en while waiting.
    @(posedge clk);
    #1;
    dmem_en = 1'b1; dmem_wr = 1'b1; dmem_size = 4'b1000;
    dmem_addr = 32'h20; dmem_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    dmem_en = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus("after_abort", 1'b0, 4'b1000, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    // Store cut off by reset on its completion edge.
    @(posedge clk);
    #1;
    dmem_en = 1'b1; dmem_wr = 1'b1; dmem_size = 4'b1000;
    dmem_addr = 32'h20; dmem_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_en = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus("after_reset", 1'b0, 4'b1000, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    applyStimulus("b2b_first",  1'b0, 4'b1000, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
`ifdef ELBETH_DMEM_MISALIGN_TRAP_EN
    applyStimulus("b2b_second", 1'b0, 4'b1000, 1'b0, 32'h10, 32'h0, 32'h80AD1234, 1'b0, 1'b0);
`else
    applyStimulus("b2b_second", 1'b0, 4'b1000, 1'b0, 32'h10, 32'h0, 32'hBEEF1234, 1'b0, 1'b0);
`endif

    applyStimulus("wrap_st", 1'b1, 4'b1000, 1'b0, 32'h1000, 32'h5A5A1234, 32'h0, 1'b0, 1'b0);
    applyStimulus("wrap_ld", 1'b0, 4'b1000, 1'b0, 32'h0000, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);
    applyStimulus("wrap_hi", 1'b0, 4'b0010, 1'b1, 32'hFFFFF002, 32'h0, 32'h00005A5A, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/elbeth_dmem_responder.md
Name: elbeth_dmem_responder

Overview:
Data-memory slave on the far end of the pipeline's dmem en/ready request interface. It accepts load/store requests from the execute stage and applies byte-lane write enables. It returns sign- or zero-extended load data and signals completion with a one-cycle ready pulse after a programmable wait. The execute stage stalls while en=1 and ready=0, so the request fields are stable for the whole transaction.

Parameters:
ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (1024 words default)
LATENCY, 2, cycles from request acceptance to ready pulse; legal range 1..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low
dmem_en  input  1  request valid; held until ready sampled high
dmem_wr  input  1  1=store, 0=load
dmem_size  input  4  0001 byte, 0010 halfword, 1000 word; other codes illegal
dmem_sign  input  1  loads only: 1=sign-extend, 0=zero-extend
dmem_addr  input  32  byte address
dmem_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
dmem_rdata  output  32  load result, valid only in the ready cycle
dmem_ready  output  1  one-cycle completion pulse
dmem_fault  output  1  valid with ready: request rejected (misaligned/illegal size)

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, counter=0, dmem_ready=0, dmem_fault=0, dmem_rdata=0. Memory array not cleared. Reset mid-transaction aborts it; no write occurs.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if dmem_en=1 -> WAIT, counter loaded with LATENCY-1; if LATENCY=1 go directly to RESP.
- WAIT: counter decrements each cycle; at 0 -> RESP. If dmem_en drops -> IDLE, transaction abandoned, no write.
- RESP: dmem_ready=1 for exactly this cycle. Store commits on this edge. rdata/fault are registered outputs valid in this cycle. Next state IDLE.
- Latency: en first high in cycle t (state IDLE) -> ready high in cycle t+LATENCY.
- Back-to-back: after RESP, IDLE accepts a new en in the immediately following cycle; throughput is one request per LATENCY+1 cycles.
- Word index = dmem_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH.
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word: all four lanes.
- Load: the selected byte/half is shifted to bit 0 and extended per dmem_sign. A word load ignores dmem_sign. A store returns rdata=0.
- Fault: raised for half with addr[0]=1, word with addr[1:0]!=0, or an illegal size code. On fault: no memory access, rdata=0, ready still pulses after the normal LATENCY, fault=1 only in the ready cycle.
- dmem_fault=0 and dmem_ready=0 in every cycle other than RESP.

Optional Feature:
ELBETH_DMEM_MISALIGN_TRAP_EN
- Defined: fault detection exactly as in Behaviour.
- Undefined: dmem_fault is tied to 0. Misaligned addresses are force-aligned: half clears addr[0], word clears addr[1:0]. An illegal size code performs a word access. Normal ready timing is kept.

Test Plan:
1. LATENCY=2, store word 0xDEADBEEF @0x10 (en at cycle t) -> ready=1 at t+2 only, fault=0; load word @0x10 -> rdata=0xDEADBEEF.
2. Store byte 0x80 @0x13 over 0xDEADBEEF -> word @0x10 reads 0x80ADBEEF. Load byte @0x13 with sign=1 -> 0xFFFFFF80; with sign=0 -> 0x00000080.
3. Load half @0x12 from 0x80ADBEEF, sign=1 -> 0xFFFF80AD. Store half 0x1234 @0x10 -> word reads 0x80AD1234.
4. Trap macro defined: load word @0x11 -> ready at t+2, fault=1, rdata=0. Store word @0x12 -> fault=1 and memory unchanged. Size 0100 -> fault=1. Macro undefined: load word @0x11 -> returns word @0x10, fault=0.
5. Abort and reset: store with en dropped in WAIT -> no ready, memory unchanged. rst=0 during WAIT -> ready=0 next cycle, state IDLE, memory unchanged.
6. Back-to-back and wrap: two loads back-to-back -> ready pulses at t+2 and t+5. ADDR_WIDTH=10: store @0x1000 then load @0x0000 -> same data.
